// File: rtl/img_pkg.sv
// Shared constants for the image filter blocks: emboss direction codes,
// pipeline latency and the reset-time offset bias.
package img_pkg;

  typedef enum logic [1:0] {
    DIR_LEFT = 2'd0,
    DIR_UP   = 2'd1,
    DIR_UL   = 2'd2,
    DIR_UR   = 2'd3
  } emb_dir_e;

  localparam int MODE_INV_BIT = 2;
  localparam int EMB_LAT      = 3;
  localparam int ROW_W        = 12;

  // Default offset is mid-scale, so a zero difference lands on grey.
  function automatic int def_offset(input int data_w);
    return 1 << (data_w - 1);
  endfunction

endpackage

// File: rtl/image_line_buf.sv
// Simple dual-port line memory, DEPTH x WIDTH. A read and a write to the same
// address in one cycle return the old contents.
module image_line_buf #(
  parameter int DEPTH  = 1280,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/image_emboss_filter.sv
// Multi-channel 3x3 relief filter: clamped (centre - neighbour) + offset,
// three-clock fixed latency with hsync/vsync/de delayed alongside the data.
module image_emboss_filter
  import img_pkg::*;
#(
  parameter int   DATA_W   = 8,
  parameter int   CHANNELS = 1,
  parameter int   IMG_W    = 1280,
  parameter logic VS_ACT   = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  input  logic                         hsync,
  input  logic                         vsync,
  input  logic                         de,
  input  logic [2:0]                   mode,
  input  logic [DATA_W-1:0]            offset,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic                         o_hsync,
  output logic                         o_vsync,
  output logic                         o_de
);

  localparam int                COL_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [COL_W-1:0]  COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX = '1;
  localparam logic [DATA_W-1:0] OFF_RST = DATA_W'(def_offset(DATA_W));
  localparam int                PIX_W   = CHANNELS * DATA_W;

  // Stream qualifier: in_data is consumed on every cycle with de=1; there is
  // no back-pressure, and o_de marks each produced pixel exactly EMB_LAT later.
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic               de_prev;
  logic               vs_prev;
  logic               de_fall;
  logic               vs_edge;
  logic [2:0]         mode_q;
  logic [DATA_W-1:0]  off_q;

  logic [EMB_LAT-1:0] de_dly;
  logic [EMB_LAT-1:0] hs_dly;
  logic [EMB_LAT-1:0] vs_dly;
  logic [COL_W-1:0]   s1_col;
  logic               s1_border;
  logic               s2_border;
  logic [PIX_W-1:0]   px_res;

  assign de_fall = de_prev && !de;
  assign vs_edge = (vsync == VS_ACT) && (vs_prev != VS_ACT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col     <= '0;
      row     <= '0;
      de_prev <= 1'b0;
      vs_prev <= VS_ACT;
      mode_q  <= '0;
      off_q   <= OFF_RST;
    end else begin
      de_prev <= de;
      vs_prev <= vsync;
      if (de) begin
        if (col != COL_MAX) col <= col + COL_W'(1);
      end else if (de_fall) begin
        col <= '0;
      end
      // The vsync edge takes priority over a coincident end of line.
      if (vs_edge) begin
        row    <= '0;
        mode_q <= mode;
        off_q  <= offset;
      end else if (de_fall && (row != ROW_MAX)) begin
        row <= row + ROW_W'(1);
      end
    end
  end

  // S1/S2 control: sync delay line, border flag and buffer write-back address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_dly    <= '0;
      hs_dly    <= '0;
      vs_dly    <= '0;
      s1_col    <= '0;
      s1_border <= 1'b0;
      s2_border <= 1'b0;
    end else begin
      de_dly    <= {de_dly[EMB_LAT-2:0], de};
      hs_dly    <= {hs_dly[EMB_LAT-2:0], hsync};
      vs_dly    <= {vs_dly[EMB_LAT-2:0], vsync};
      s1_col    <= col;
      s1_border <= (row < ROW_W'(2)) || (col < COL_W'(2));
      s2_border <= s1_border;
    end
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [DATA_W-1:0]        top_rd;
    logic [DATA_W-1:0]        mid_rd;
    logic [DATA_W-1:0]        w_top [3];
    logic [DATA_W-1:0]        w_mid [3];
    logic [DATA_W-1:0]        n_px;
    logic signed [DATA_W:0]   diff;
    logic signed [DATA_W+1:0] res;
    logic [DATA_W-1:0]        px_out;

    // buf0 holds row-2 and is refilled one cycle later from buf1's read data.
    image_line_buf #(.DEPTH(IMG_W), .WIDTH(DATA_W), .ADDR_W(COL_W)) u_buf0 (
      .clk     (clk),
      .rd_en   (de),
      .rd_addr (col),
      .rd_data (top_rd),
      .wr_en   (de_dly[0]),
      .wr_addr (s1_col),
      .wr_data (mid_rd)
    );

    image_line_buf #(.DEPTH(IMG_W), .WIDTH(DATA_W), .ADDR_W(COL_W)) u_buf1 (
      .clk     (clk),
      .rd_en   (de),
      .rd_addr (col),
      .rd_data (mid_rd),
      .wr_en   (de),
      .wr_addr (col),
      .wr_data (in_data[ch*DATA_W +: DATA_W])
    );

    // Index 2 is the newest column; the current-row taps feed no neighbour.
    always_ff @(posedge clk) begin
      if (de_dly[0]) begin
        w_top[0] <= w_top[1];
        w_top[1] <= w_top[2];
        w_top[2] <= top_rd;
        w_mid[0] <= w_mid[1];
        w_mid[1] <= w_mid[2];
        w_mid[2] <= mid_rd;
      end
    end

    always_comb begin
      n_px = w_mid[0];
      case (emb_dir_e'(mode_q[1:0]))
        DIR_LEFT: n_px = w_mid[0];
        DIR_UP:   n_px = w_top[1];
        DIR_UL:   n_px = w_top[0];
        DIR_UR:   n_px = w_top[2];
      endcase
      if (mode_q[MODE_INV_BIT]) diff = $signed({1'b0, n_px}) - $signed({1'b0, w_mid[1]});
      else                      diff = $signed({1'b0, w_mid[1]}) - $signed({1'b0, n_px});
      res = $signed({diff[DATA_W], diff}) + $signed({2'b00, off_q});
      // res spans [-2^DATA_W+1, 2^(DATA_W+1)-2]: sign bit or bit DATA_W flags a clamp.
      if (res[DATA_W+1])    px_out = '0;
      else if (res[DATA_W]) px_out = '1;
      else                  px_out = res[DATA_W-1:0];
    end

    assign px_res[ch*DATA_W +: DATA_W] = px_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               out_data <= '0;
    else if (!de_dly[1])   out_data <= '0;
    else if (s2_border)    out_data <= {CHANNELS{off_q}};
    else                   out_data <= px_res;
  end

  assign o_de    = de_dly[EMB_LAT-1];
  assign o_hsync = hs_dly[EMB_LAT-1];
  assign o_vsync = vs_dly[EMB_LAT-1];

endmodule

// File: tb/tb_image_emboss_filter.sv
// Directed bench for image_emboss_filter: 8x8 frames on three channels, with
// per-pixel expected values queued as each input pixel is driven.
module tb_image_emboss_filter;
  import img_pkg::*;

  localparam int DW = 8;
  localparam int CH = 3;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int PW = DW * CH;

  localparam int P_FLAT   = 0;
  localparam int P_HRAMP  = 1;
  localparam int P_VRAMP  = 2;
  localparam int P_CHECK  = 3;
  localparam int P_DIAG   = 4;
  localparam int P_CHRAMP = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] in_data = '0;
  logic          hsync = 1'b0;
  logic          vsync = 1'b1;
  logic          de = 1'b0;
  logic [2:0]    mode = 3'd0;
  logic [DW-1:0] offset = 8'd128;
  logic [PW-1:0] out_data;
  logic          o_hsync;
  logic          o_vsync;
  logic          o_de;

  int total = 0;
  int bad   = 0;
  logic [PW-1:0]      exp_q[$];
  logic [EMB_LAT-1:0] de_h = '0;
  logic [EMB_LAT-1:0] hs_h = '0;
  logic [EMB_LAT-1:0] vs_h = '0;

  image_emboss_filter #(.DATA_W(DW), .CHANNELS(CH), .IMG_W(W), .VS_ACT(1'b0)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .hsync    (hsync),
    .vsync    (vsync),
    .de       (de),
    .mode     (mode),
    .offset   (offset),
    .out_data (out_data),
    .o_hsync  (o_hsync),
    .o_vsync  (o_vsync),
    .o_de     (o_de)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; compare outputs #1 after the edge against the
  // inputs sampled EMB_LAT edges earlier.
  task automatic step();
    logic [PW-1:0] e;
    @(posedge clk);
    #1;
    de_h = {de_h[EMB_LAT-2:0], de & ~rst};
    hs_h = {hs_h[EMB_LAT-2:0], hsync & ~rst};
    vs_h = {vs_h[EMB_LAT-2:0], vsync & ~rst};
    chk("o_de", o_de, de_h[EMB_LAT-1]);
    chk("o_hsync", o_hsync, hs_h[EMB_LAT-1]);
    chk("o_vsync", o_vsync, vs_h[EMB_LAT-1]);
    if (de_h[EMB_LAT-1]) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      chk("pixel", out_data, e);
    end else begin
      chk("idle_data", out_data, 0);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic d, input logic hs, input logic vs, input logic [PW-1:0] data);
    de      = d;
    hsync   = hs;
    vsync   = vs;
    in_data = d ? data : '0;
    step();
  endtask

  function automatic logic [DW-1:0] pix(input int pat, input int k, input int r, input int c);
    case (pat)
      P_FLAT:  return 8'd100;
      P_HRAMP: return 8'(10 * c);
      P_VRAMP: return 8'(20 * r);
      P_CHECK: return ((r + c) % 2 == 1) ? 8'd255 : 8'd0;
      P_DIAG:  return 8'(5 * c + 20 * r);
      default: return 8'((k + 1) * 10 * c);
    endcase
  endfunction

  // exp_int holds the hand-computed interior value per channel; board selects
  // the checkerboard clamp rule (255 where the centre is 255, else 0).
  task automatic run_frame(input int pat, input logic [2:0] m, input logic [DW-1:0] off,
                           input logic [PW-1:0] exp_int, input bit board,
                           input int mid_row, input logic [2:0] mid_mode, input int rst_row);
    logic [PW-1:0] d;
    logic [PW-1:0] e;
    mode   = m;
    offset = off;
    repeat (2) drive(1'b0, 1'b0, 1'b1, '0);
    repeat (2) drive(1'b0, 1'b0, 1'b0, '0);
    repeat (3) drive(1'b0, 1'b0, 1'b1, '0);
    for (int r = 0; r < H; r++) begin
      if (r == mid_row) mode = mid_mode;
      drive(1'b0, 1'b1, 1'b1, '0);
      drive(1'b0, 1'b0, 1'b1, '0);
      for (int c = 0; c < W; c++) begin
        if (r == rst_row && c == 5) begin
          chk("pre_rst_o_de", o_de, 1);
          rst     = 1'b1;
          de      = 1'b0;
          in_data = '0;
          #1;
          chk("rst_out_data", out_data, 0);
          chk("rst_o_de", o_de, 0);
          chk("rst_o_hsync", o_hsync, 0);
          chk("rst_o_vsync", o_vsync, 0);
          exp_q.delete();
          de_h = '0;
          hs_h = '0;
          vs_h = '0;
          repeat (3) drive(1'b0, 1'b0, 1'b1, '0);
          rst = 1'b0;
          repeat (3) drive(1'b0, 1'b0, 1'b1, '0);
          return;
        end
        for (int k = 0; k < CH; k++) begin
          d[k*DW +: DW] = pix(pat, k, r, c);
          if (r < 2 || c < 2)
            e[k*DW +: DW] = off;
          else if (board)
            e[k*DW +: DW] = (pix(pat, k, r - 1, c - 1) == 8'd255) ? 8'd255 : 8'd0;
          else
            e[k*DW +: DW] = exp_int[k*DW +: DW];
        end
        exp_q.push_back(e);
        drive(1'b1, 1'b0, 1'b1, d);
      end
      repeat (3) drive(1'b0, 1'b0, 1'b1, '0);
    end
    repeat (4) drive(1'b0, 1'b0, 1'b1, '0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) drive(1'b0, 1'b0, 1'b1, '0);
    chk("reset_out_data", out_data, 0);
    chk("reset_o_de", o_de, 0);
    chk("reset_o_vsync", o_vsync, 0);
    rst = 1'b0;
    repeat (2) drive(1'b0, 1'b0, 1'b1, '0);

    // flat, horizontal ramp, vertical ramp (normal and inverted)
    run_frame(P_FLAT,  3'd0, 8'd128, {3{8'd128}}, 1'b0, -1, 3'd0, -1);
    run_frame(P_HRAMP, 3'd0, 8'd128, {3{8'd138}}, 1'b0, -1, 3'd0, -1);
    run_frame(P_VRAMP, 3'd1, 8'd128, {3{8'd148}}, 1'b0, -1, 3'd0, -1);
    run_frame(P_VRAMP, 3'd5, 8'd128, {3{8'd108}}, 1'b0, -1, 3'd0, -1);

    // checkerboard clamps both ways
    run_frame(P_CHECK, 3'd0, 8'd128, '0, 1'b1, -1, 3'd0, -1);

    // diagonal ramp 5*col+20*row: up-left 25, up-right 15, inverted up-left -25
    run_frame(P_DIAG, 3'd2, 8'd128, {3{8'd153}}, 1'b0, -1, 3'd0, -1);
    run_frame(P_DIAG, 3'd3, 8'd128, {3{8'd143}}, 1'b0, -1, 3'd0, -1);
    run_frame(P_DIAG, 3'd6, 8'd128, {3{8'd103}}, 1'b0, -1, 3'd0, -1);

    // non-default offset: border 50, interior 20+50
    run_frame(P_VRAMP, 3'd1, 8'd50, {3{8'd70}}, 1'b0, -1, 3'd0, -1);

    // mode port changes mid-frame without effect; next frame picks it up
    run_frame(P_HRAMP, 3'd0, 8'd128, {3{8'd138}}, 1'b0, 4, 3'd1, -1);
    run_frame(P_HRAMP, 3'd1, 8'd128, {3{8'd128}}, 1'b0, -1, 3'd0, -1);

    // reset mid-line, then a clean frame
    run_frame(P_HRAMP, 3'd0, 8'd128, {3{8'd138}}, 1'b0, -1, 3'd0, 3);
    run_frame(P_HRAMP, 3'd0, 8'd128, {3{8'd138}}, 1'b0, -1, 3'd0, -1);

    // per-channel ramps (k+1)*10*col
    run_frame(P_CHRAMP, 3'd0, 8'd128, {8'd158, 8'd148, 8'd138}, 1'b0, -1, 3'd0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
